// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART loopback byte buffer.
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT_BUSY,
        TX_WAIT_READY
    } tx_state_t;

    typedef enum logic {
        ARMED,
        WAIT_LOW
    } rx_guard_t;

    localparam int unsigned DefaultDepth = 16;
    localparam int unsigned DefaultDataW = 8;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with registered count and full/empty flags.
module uart_sync_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_W-1:0]        din_i,
    output logic [DATA_W-1:0]        dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [PtrW-1:0]   rptr_q, rptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              do_push, do_pop;

    // Callers already guard push/pop; the extra qualification keeps pointers sane regardless.
    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        wptr_d  = do_push ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d  = do_pop ? rptr_q + PtrW'(1) : rptr_q;
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == CntW'(DEPTH));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[rptr_q];
    assign count_o = count_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule

// File: rtl/uart_loop_fifo.sv
// Buffers received UART bytes and launches the transmitter one byte per busy/ready cycle.
module uart_loop_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = DefaultDepth,
    parameter int unsigned DATA_W = DefaultDataW
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_rx_done,
    input  logic [DATA_W-1:0]      i_rx_data,
    output logic                   o_rx_ack,
    input  logic                   i_tx_ready,
    output logic                   o_tx_valid,
    output logic [DATA_W-1:0]      o_tx_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full,
    output logic                   o_overflow
);
    rx_guard_t         rx_q, rx_d;
    tx_state_t         tx_q, tx_d;
    logic              rx_ack_q, rx_ack_d;
    logic              overflow_q, overflow_d;
    logic              tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;

    logic              push, pop;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_empty, fifo_full;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (i_rx_data),
        .dout_o  (fifo_dout),
        .count_o (o_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Receive guard: one write/ack per i_rx_done assertion; full is the registered flag.
    always_comb begin
        rx_d       = rx_q;
        rx_ack_d   = 1'b0;
        overflow_d = overflow_q;
        push       = 1'b0;
        unique case (rx_q)
            ARMED: begin
                if (i_rx_done) begin
                    rx_ack_d = 1'b1;
                    rx_d     = WAIT_LOW;
                    if (fifo_full) begin
                        overflow_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            WAIT_LOW: begin
                if (!i_rx_done) begin
                    rx_d = ARMED;
                end
            end
            default: rx_d = ARMED;
        endcase
    end

    always_comb begin
        tx_d       = tx_q;
        tx_valid_d = 1'b0;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        unique case (tx_q)
            TX_IDLE: begin
                if (!fifo_empty && i_tx_ready) begin
                    pop        = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_data_d  = fifo_dout;
                    tx_d       = TX_WAIT_BUSY;
                end
            end
            TX_WAIT_BUSY: begin
                if (!i_tx_ready) begin
                    tx_d = TX_WAIT_READY;
                end
            end
            TX_WAIT_READY: begin
                if (i_tx_ready) begin
                    tx_d = TX_IDLE;
                end
            end
            default: tx_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_q       <= ARMED;
            tx_q       <= TX_IDLE;
            rx_ack_q   <= 1'b0;
            overflow_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            rx_ack_q   <= rx_ack_d;
            overflow_q <= overflow_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign o_rx_ack   = rx_ack_q;
    assign o_tx_valid = tx_valid_q;
    assign o_tx_data  = tx_data_q;
    assign o_empty    = fifo_empty;
    assign o_full     = fifo_full;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_uart_loop_fifo.sv
// Directed bench for uart_loop_fifo: handshakes, ordering, overflow, wrap and reset.
module tb_uart_loop_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       rx_ack;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overflow;

    int n_total = 0;
    int n_bad   = 0;
    logic [7:0] exp_q[$];

    uart_loop_fifo #(
        .DEPTH  (16),
        .DATA_W (8)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rx_done  (rx_done),
        .i_rx_data  (rx_data),
        .o_rx_ack   (rx_ack),
        .i_tx_ready (tx_ready),
        .o_tx_valid (tx_valid),
        .o_tx_data  (tx_data),
        .o_count    (count),
        .o_empty    (empty),
        .o_full     (full),
        .o_overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, output int ack_seen);
        rx_done = 1'b1;
        rx_data = d;
        tick();
        ack_seen = int'(rx_ack);
        rx_done = 1'b0;
        tick();
    endtask

    // Transmitter model: ready drops for two cycles after each launch.
    task automatic drain(input int n);
        int got_n;
        int budget;
        got_n = 0;
        budget = 300;
        tx_ready = 1'b1;
        while (got_n < n && budget > 0) begin
            tick();
            budget--;
            if (tx_valid) begin
                check_eq("tx_data", int'(tx_data), int'(exp_q.pop_front()));
                got_n++;
                tx_ready = 1'b0;
                tick();
                check_eq("tx_valid_width", int'(tx_valid), 0);
                tick();
                tx_ready = 1'b1;
            end
        end
        check_eq("drain_cnt", got_n, n);
    endtask

    initial begin
        int ack;
        int acks;
        int valids;

        rst      = 1'b1;
        rx_done  = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        tick();
        tick();
        check_eq("rst_ack", int'(rx_ack), 0);
        check_eq("rst_valid", int'(tx_valid), 0);
        check_eq("rst_data", int'(tx_data), 0);
        check_eq("rst_count", int'(count), 0);
        check_eq("rst_empty", int'(empty), 1);
        check_eq("rst_full", int'(full), 0);
        check_eq("rst_ovf", int'(overflow), 0);
        rst = 1'b0;
        tick();

        // Single byte pass-through, 2-cycle latency.
        tx_ready = 1'b1;
        rx_done  = 1'b1;
        rx_data  = 8'hA5;
        tick();
        check_eq("t1_ack", int'(rx_ack), 1);
        check_eq("t1_count_n1", int'(count), 1);
        check_eq("t1_valid_n1", int'(tx_valid), 0);
        rx_done = 1'b0;
        tick();
        check_eq("t1_ack_n2", int'(rx_ack), 0);
        check_eq("t1_valid_n2", int'(tx_valid), 1);
        check_eq("t1_data", int'(tx_data), 32'hA5);
        check_eq("t1_count_n2", int'(count), 0);
        tx_ready = 1'b0;
        tick();
        check_eq("t1_valid_n3", int'(tx_valid), 0);
        tick();
        tx_ready = 1'b1;
        tick();
        tick();
        check_eq("t1_no_relaunch", int'(tx_valid), 0);

        // Held rx_done produces one write only.
        tx_ready = 1'b0;
        rx_done  = 1'b1;
        rx_data  = 8'h11;
        tick();
        check_eq("t2_ack", int'(rx_ack), 1);
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            acks += int'(rx_ack);
        end
        check_eq("t2_extra_acks", acks, 0);
        check_eq("t2_count_held", int'(count), 1);
        rx_done = 1'b0;
        tick();
        rx_done = 1'b1;
        rx_data = 8'h22;
        tick();
        check_eq("t2_ack2", int'(rx_ack), 1);
        check_eq("t2_count2", int'(count), 2);
        rx_done = 1'b0;
        tick();
        exp_q = '{8'h11, 8'h22};
        drain(2);

        // Fill to full, then overflow.
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(i), ack);
            check_eq("t3_fill_ack", ack, 1);
        end
        check_eq("t3_full", int'(full), 1);
        check_eq("t3_count", int'(count), 16);
        check_eq("t3_ovf_pre", int'(overflow), 0);
        push_byte(8'h55, ack);
        check_eq("t3_ovf_ack", ack, 1);
        check_eq("t3_ovf", int'(overflow), 1);
        check_eq("t3_count_ovf", int'(count), 16);
        exp_q = {};
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        drain(16);
        valids = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            valids += int'(tx_valid);
        end
        check_eq("t3_no_extra_tx", valids, 0);
        check_eq("t3_empty", int'(empty), 1);
        check_eq("t3_count_end", int'(count), 0);
        check_eq("t3_ovf_sticky", int'(overflow), 1);

        // Simultaneous push and pop at count 3.
        tx_ready = 1'b0;
        push_byte(8'h30, ack);
        push_byte(8'h31, ack);
        push_byte(8'h32, ack);
        check_eq("t4_count3", int'(count), 3);
        rx_done  = 1'b1;
        rx_data  = 8'h33;
        tx_ready = 1'b1;
        tick();
        check_eq("t4_count_same", int'(count), 3);
        check_eq("t4_ack", int'(rx_ack), 1);
        check_eq("t4_valid", int'(tx_valid), 1);
        check_eq("t4_data", int'(tx_data), 32'h30);
        rx_done  = 1'b0;
        tx_ready = 1'b0;
        tick();
        exp_q = '{8'h31, 8'h32, 8'h33};
        drain(3);

        // 40 bytes of traffic in batches to wrap the pointers.
        for (int b = 0; b < 4; b++) begin
            tx_ready = 1'b0;
            exp_q = {};
            for (int i = 0; i < 10; i++) begin
                push_byte(8'(8'h40 + b * 10 + i), ack);
                exp_q.push_back(8'(8'h40 + b * 10 + i));
            end
            check_eq("t4_batch_count", int'(count), 10);
            drain(10);
        end
        tick();
        tick();

        // Reset with count 7 while TX waits for ready.
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_byte(8'(8'h80 + i), ack);
        tx_ready = 1'b1;
        tick();
        check_eq("t5_launch", int'(tx_valid), 1);
        check_eq("t5_launch_data", int'(tx_data), 32'h80);
        tx_ready = 1'b0;
        tick();
        check_eq("t5_count7", int'(count), 7);
        rst = 1'b1;
        tick();
        check_eq("t5_count", int'(count), 0);
        check_eq("t5_empty", int'(empty), 1);
        check_eq("t5_ovf", int'(overflow), 0);
        check_eq("t5_valid", int'(tx_valid), 0);
        rst      = 1'b0;
        tx_ready = 1'b1;
        valids   = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            valids += int'(tx_valid);
        end
        check_eq("t5_no_tx", valids, 0);
        rx_done = 1'b1;
        rx_data = 8'hC3;
        tick();
        check_eq("t5_ack", int'(rx_ack), 1);
        rx_done = 1'b0;
        tick();
        check_eq("t5_valid_new", int'(tx_valid), 1);
        check_eq("t5_data_new", int'(tx_data), 32'hC3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
